// File: rtl/controlador_botao_pkg.sv
// Shared types and default constants for the push-button conditioner.
// Contents:
//   estado_t            - lockout FSM state encoding (IDLE, LOCK)
//   DEF_SYNC_STAGES     - default synchroniser depth
//   DEF_LOCKOUT         - default lockout window in clock cycles
//   DEF_REPEAT_DELAY    - default hold time before the first auto-repeat pulse
//   DEF_REPEAT_PERIOD   - default spacing between auto-repeat pulses
package controlador_botao_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } estado_t;

    localparam int unsigned DEF_SYNC_STAGES   = 32'd2;
    localparam int unsigned DEF_LOCKOUT       = 32'd256;
    localparam int unsigned DEF_REPEAT_DELAY  = 32'd512;
    localparam int unsigned DEF_REPEAT_PERIOD = 32'd128;

endpackage

// File: rtl/controlador_botao_sync.sv
// N-flop synchroniser for an asynchronous level input.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low clear of every stage
//   d     - asynchronous input level
//   q     - synchronised level (last stage)
module botao_sync #(
    parameter int unsigned N = 32'd2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_r;

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[N-2:0], d};
        end
    end

    assign q = sync_r[N-1];

endmodule

// File: rtl/controlador_botao.sv
// Push-button conditioner: synchronises b_in, detects press edges and emits
// one single-cycle pulse per accepted press, followed by a lockout window in
// which further presses are discarded.
// Optional feature macro: BTN_AUTOREPEAT_EN (hold-to-repeat pulses).
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   b_in  - raw button level (1 = pressed), asynchronous to clk
//   b_out - registered one-cycle press pulse
module controlador_botao
    import controlador_botao_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT,
    parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b_in,
    output logic b_out
);

    localparam int unsigned      CNT_W    = $clog2(LOCKOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 32'd1);

    logic             b_sync_s;
    logic             b_prev_r;
    logic             rise_s;
    logic             repeat_s;
    logic             pulse_s;
    estado_t          state_r;
    estado_t          state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             b_out_r;

    botao_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (b_in),
        .q     (b_sync_s)
    );

    // Delayed copy of the synchronised level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_prev_r <= 1'b0;
        end else begin
            b_prev_r <= b_sync_s;
        end
    end

    assign rise_s = b_sync_s & ~b_prev_r;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 32'd1);

    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_target_s;
    logic              hold_active_r;
    logic              hold_first_r;

    // The first repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD.
    assign hold_target_s = hold_first_r ? HOLD_W'(REPEAT_DELAY - 32'd1)
                                        : HOLD_W'(REPEAT_PERIOD - 32'd1);
    assign repeat_s      = hold_active_r & b_sync_s & (hold_cnt_r == hold_target_s);

    // Hold counter: restarts on every pulse, cleared as soon as the button is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r    <= '0;
            hold_active_r <= 1'b0;
            hold_first_r  <= 1'b0;
        end else if (!b_sync_s) begin
            hold_cnt_r    <= '0;
            hold_active_r <= 1'b0;
            hold_first_r  <= 1'b0;
        end else if (pulse_s) begin
            hold_cnt_r    <= '0;
            hold_active_r <= 1'b1;
            hold_first_r  <= ~repeat_s;
        end else if (hold_active_r && (hold_cnt_r != {HOLD_W{1'b1}})) begin
            hold_cnt_r    <= hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_r    <= hold_cnt_r;
        end
    end
`else
    logic repeat_unused_s;

    assign repeat_s        = 1'b0;
    assign repeat_unused_s = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    // State, lockout counter and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            b_out_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            b_out_r <= pulse_s;
        end
    end

    // Next-state logic: a rise only counts in IDLE; LOCK ends when the counter is spent.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s || repeat_s) begin
                    state_next_s = LOCK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOCK: begin
                if (repeat_s) begin
                    state_next_s = LOCK;
                end else if (cnt_r == '0) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOCK;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output logic: pulse request and lockout counter load/saturating decrement.
    always_comb begin
        pulse_s    = 1'b0;
        cnt_next_s = cnt_r;
        case (state_r)
            IDLE: begin
                if (rise_s || repeat_s) begin
                    pulse_s    = 1'b1;
                    cnt_next_s = CNT_LOAD;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            LOCK: begin
                if (repeat_s) begin
                    pulse_s    = 1'b1;
                    cnt_next_s = CNT_LOAD;
                end else if (cnt_r != '0) begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            default: begin
                pulse_s    = 1'b0;
                cnt_next_s = '0;
            end
        endcase
    end

    assign b_out = b_out_r;

endmodule

// File: tb/tb_controlador_botao.sv
// Directed testbench for controlador_botao. Expected pulse edge numbers are
// queued when a press is driven; a monitor queues the edge number of every
// cycle in which b_out is high, and the two queues are compared per step.
module tb_controlador_botao;

    logic clk = 1'b0;
    logic rst_n;
    logic b_in;
    logic b_out;

    int unsigned cyc = 32'd0;
    int unsigned exp_q[$];
    int unsigned got_q[$];
    int unsigned c;
    int          tests = 0;
    int          fails = 0;

    controlador_botao dut (
        .clk   (clk),
        .rst_n (rst_n),
        .b_in  (b_in),
        .b_out (b_out)
    );

    always #5 clk = ~clk;

    // Count rising edges; after edge k settles, cyc == k.
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Record the edge after which b_out was seen high.
    always @(negedge clk) begin
        if (b_out === 1'b1) got_q.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic obs, input logic exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic check_pulses(input string tag);
        int unsigned e;
        int unsigned g;
        tests++;
        assert (got_q.size() === exp_q.size()) else begin
            fails++;
            $error("FAIL %s_count: observed %0d pulses expected %0d", tag, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            tests++;
            assert (g === e) else begin
                fails++;
                $error("FAIL %s_edge: observed pulse at edge %0d expected %0d", tag, g, e);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        b_in  = 1'b0;
        step(3);
        check_val("reset_b_out", b_out, 1'b0);
        rst_n = 1'b1;

        // Idle: no pulses with the button untouched.
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_val("idle_b_out", b_out, 1'b0);
        end
        check_pulses("idle");

        // Long hold: one pulse on the third edge after the first sample.
        c = cyc;
        b_in = 1'b1;
        exp_q.push_back(c + 32'd3);
        step(512);
        check_pulses("hold512");

        // Release, long idle, press again.
        b_in = 1'b0;
        step(600);
        check_pulses("release_idle");
        c = cyc;
        b_in = 1'b1;
        exp_q.push_back(c + 32'd3);
        step(10);
        b_in = 1'b0;
        step(300);
        check_pulses("second_press");

        // Bounce and a re-press well inside the lockout.
        c = cyc;
        b_in = 1'b1; step(1);
        b_in = 1'b0; step(1);
        b_in = 1'b1; step(1);
        b_in = 1'b0; step(10);
        b_in = 1'b1; step(5);
        b_in = 1'b0;
        exp_q.push_back(c + 32'd3);
        step(300);
        check_pulses("bounce");

        // Re-press whose rise lands on the last lockout cycle: discarded.
        c = cyc;
        b_in = 1'b1;
        exp_q.push_back(c + 32'd3);
        step(5);
        b_in = 1'b0;
        step(251);
        b_in = 1'b1;
        step(20);
        b_in = 1'b0;
        step(300);
        check_pulses("early_repress");

        // Re-press whose rise lands on the IDLE re-entry cycle: accepted.
        c = cyc;
        b_in = 1'b1;
        exp_q.push_back(c + 32'd3);
        step(5);
        b_in = 1'b0;
        step(252);
        b_in = 1'b1;
        exp_q.push_back(c + 32'd260);
        step(20);
        b_in = 1'b0;
        step(300);
        check_pulses("reentry");

        // Reset while the pulse is high: b_out clears at once, lockout is aborted.
        b_in = 1'b1;
        step(3);
        check_val("pulse_before_reset", b_out, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("reset_async_b_out", b_out, 1'b0);
        b_in = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        c = cyc;
        b_in = 1'b1;
        exp_q.push_back(c + 32'd3);
        step(10);
        b_in = 1'b0;
        step(5);
        check_pulses("post_reset_press");
        step(300);

        // Button held across reset release gives exactly one pulse.
        rst_n = 1'b0;
        b_in = 1'b1;
        step(3);
        rst_n = 1'b1;
        c = cyc;
        exp_q.push_back(c + 32'd3);
        step(20);
        b_in = 1'b0;
        step(300);
        check_pulses("hold_across_reset");

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat: pulses at 0, 512, 640, 768, 896 after the first; release stops them.
        c = cyc;
        b_in = 1'b1;
        exp_q.push_back(c + 32'd3);
        exp_q.push_back(c + 32'd515);
        exp_q.push_back(c + 32'd643);
        exp_q.push_back(c + 32'd771);
        exp_q.push_back(c + 32'd899);
        step(1000);
        b_in = 1'b0;
        step(300);
        check_pulses("autorepeat");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
